// File: rtl/audio_pkg.sv
// Shared definitions for the serial-audio receive path: framing mode and
// counter-width helpers.
package audio_pkg;

  typedef enum logic {
    AUDIO_MODE_LJ  = 1'b0,
    AUDIO_MODE_I2S = 1'b1
  } audio_mode_e;

  localparam int unsigned AUDIO_MAX_CHANNELS = 8;
  localparam int unsigned AUDIO_MAX_SLOT_CW  = $clog2(AUDIO_MAX_CHANNELS);

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// SCK-domain timing generator: BCK/LRCK as registered outputs plus the
// bit/slot position and single-cycle strobes used by the receiver.
module audio_clk_gen
  import audio_pkg::*;
#(
  parameter int unsigned SLOT_W      = 24,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SCK_PER_BCK = 8,
  localparam int unsigned BIT_W      = cnt_w(SLOT_W),
  localparam int unsigned SLOT_CW    = cnt_w(CHANNELS)
) (
  input  logic               i_sck,
  input  logic               i_rst,
  input  logic               i_en,
  output logic [BIT_W-1:0]   o_bit_cnt,
  output logic [SLOT_CW-1:0] o_slot_cnt,
  output logic               o_bck,
  output logic               o_lrck,
  output logic               o_cap_en,
  output logic               o_slot_start,
  output logic               o_frame_end
);

  localparam int unsigned SCK_W = cnt_w(SCK_PER_BCK);
  localparam int unsigned HALF  = SCK_PER_BCK / 2;

  if (SCK_PER_BCK < 4 || (SCK_PER_BCK % 2) != 0) begin : g_bad_div
    $error("SCK_PER_BCK must be even and at least 4");
  end

  logic [SCK_W-1:0]   r_sck_cnt;
  logic [SCK_W-1:0]   w_sck_nxt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [SLOT_CW-1:0] r_slot_cnt;
  logic [SLOT_CW-1:0] w_slot_nxt;
  logic               w_sck_wrap;
  logic               w_bit_wrap;
  logic               w_slot_wrap;
  logic               w_cap;
  logic               r_bck;
  logic               r_lrck;

  always_comb begin
    w_sck_wrap  = (r_sck_cnt == SCK_W'(SCK_PER_BCK - 1));
    w_bit_wrap  = (r_bit_cnt == BIT_W'(SLOT_W - 1));
    w_slot_wrap = (r_slot_cnt == SLOT_CW'(CHANNELS - 1));
    w_sck_nxt   = w_sck_wrap ? '0 : r_sck_cnt + 1'b1;
    w_bit_nxt   = r_bit_cnt;
    if (w_sck_wrap) begin
      w_bit_nxt = w_bit_wrap ? '0 : r_bit_cnt + 1'b1;
    end
    w_slot_nxt  = r_slot_cnt;
    if (w_sck_wrap && w_bit_wrap) begin
      w_slot_nxt = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    end
  end

  // BCK/LRCK are decoded from the next counter values so they change on the
  // same SCK edge as the counters, not one cycle behind.
  always_ff @(posedge i_sck or posedge i_rst) begin
    if (i_rst) begin
      r_sck_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
      r_bck      <= 1'b0;
      r_lrck     <= 1'b1;
    end else if (!i_en) begin
      r_sck_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
      r_bck      <= 1'b0;
      r_lrck     <= 1'b1;
    end else begin
      r_sck_cnt  <= w_sck_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_slot_cnt <= w_slot_nxt;
      r_bck      <= (w_sck_nxt >= SCK_W'(HALF));
      r_lrck     <= (w_slot_nxt < SLOT_CW'(CHANNELS / 2));
    end
  end

  assign w_cap        = i_en && (r_sck_cnt == SCK_W'(HALF - 1));
  assign o_cap_en     = w_cap;
  assign o_slot_start = i_en && (r_sck_cnt == '0) && (r_bit_cnt == '0);
  assign o_frame_end  = w_cap && w_bit_wrap && w_slot_wrap;
  assign o_bit_cnt    = r_bit_cnt;
  assign o_slot_cnt   = r_slot_cnt;
  assign o_bck        = r_bck;
  assign o_lrck       = r_lrck;

endmodule

// File: rtl/i2s_rx_tdm.sv
// TDM / I2S serial audio receiver: captures MSB-first slots into a shadow
// frame and hands complete frames out through a valid/ready holding register.
module i2s_rx_tdm
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 24,
  parameter int unsigned SLOT_W      = 24,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SCK_PER_BCK = 8,
  parameter int unsigned MODE        = 0
) (
  input  logic                         SCK,
  input  logic                         begin_receive,
  input  logic                         rx_en,
  input  logic                         in,
  output logic                         BCK,
  output logic                         LRCK,
  output logic [CHANNELS*SAMPLE_W-1:0] frame_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         overrun,
  input  logic                         clr_overrun
);

  localparam audio_mode_e RX_MODE = (MODE == 0) ? AUDIO_MODE_LJ : AUDIO_MODE_I2S;
  localparam int          OFF     = (RX_MODE == AUDIO_MODE_I2S) ? 1 : 0;
  localparam int unsigned BIT_W   = cnt_w(SLOT_W);
  localparam int unsigned SLOT_CW = cnt_w(CHANNELS);
  localparam int unsigned FRAME_W = CHANNELS * SAMPLE_W;

  if (CHANNELS < 2 || CHANNELS > AUDIO_MAX_CHANNELS || (CHANNELS % 2) != 0) begin : g_bad_ch
    $error("CHANNELS must be even and within 2..%0d", AUDIO_MAX_CHANNELS);
  end
  if (MODE > 1 || SAMPLE_W < 2 || (SAMPLE_W + MODE) > SLOT_W) begin : g_bad_slot
    $error("sample window does not fit in the slot");
  end

  logic [BIT_W-1:0]    w_bit_cnt;
  logic [SLOT_CW-1:0]  w_slot_cnt;
  logic                w_cap_en;
  logic                w_slot_start;
  logic                w_frame_end;
  logic                w_in_win;
  logic                w_win_last;
  logic                w_commit;
  logic                w_accept;
  logic [SAMPLE_W-1:0] r_shift;
  logic [FRAME_W-1:0]  r_shadow;
  logic                r_commit;
  logic [FRAME_W-1:0]  r_frame_data;
  logic                r_frame_valid;
  logic                r_overrun;

  audio_clk_gen #(
    .SLOT_W      (SLOT_W),
    .CHANNELS    (CHANNELS),
    .SCK_PER_BCK (SCK_PER_BCK)
  ) u_clk_gen (
    .i_sck        (SCK),
    .i_rst        (begin_receive),
    .i_en         (rx_en),
    .o_bit_cnt    (w_bit_cnt),
    .o_slot_cnt   (w_slot_cnt),
    .o_bck        (BCK),
    .o_lrck       (LRCK),
    .o_cap_en     (w_cap_en),
    .o_slot_start (w_slot_start),
    .o_frame_end  (w_frame_end)
  );

  assign w_in_win   = (int'(w_bit_cnt) >= OFF) && (int'(w_bit_cnt) < OFF + int'(SAMPLE_W));
  assign w_win_last = (int'(w_bit_cnt) == OFF + int'(SAMPLE_W) - 1);
  assign w_commit   = r_commit && rx_en;
  assign w_accept   = r_frame_valid && frame_ready;

  // Bits are shifted in MSB-first and the completed word is written to its
  // shadow slot on the last window bit; equivalent to per-bit indexed writes.
  always_ff @(posedge SCK or posedge begin_receive) begin
    if (begin_receive) begin
      r_shift  <= '0;
      r_shadow <= '0;
      r_commit <= 1'b0;
    end else if (!rx_en) begin
      r_shift  <= '0;
      r_shadow <= '0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= w_frame_end;
      if (w_slot_start) begin
        r_shift <= '0;
      end else if (w_cap_en && w_in_win) begin
        r_shift <= {r_shift[SAMPLE_W-2:0], in};
      end
      if (w_cap_en && w_win_last) begin
        r_shadow[int'(w_slot_cnt)*int'(SAMPLE_W) +: SAMPLE_W] <= {r_shift[SAMPLE_W-2:0], in};
      end
    end
  end

  always_ff @(posedge SCK or posedge begin_receive) begin
    if (begin_receive) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_commit && (!r_frame_valid || frame_ready)) begin
        r_frame_data  <= r_shadow;
        r_frame_valid <= 1'b1;
      end else if (w_accept) begin
        r_frame_valid <= 1'b0;
      end
      if (w_commit && r_frame_valid && !frame_ready) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Directed bench for i2s_rx_tdm: a default LJ instance and a 4-slot I2S
// instance, driven by a codec model with a queue of expected frames.
module tb_i2s_rx_tdm;

  logic SCK = 1'b0;
  always #5 SCK = ~SCK;

  logic rst1, rst2, en1, en2, din, rdy, clr, sel;
  logic in1, in2, rdy1, rdy2, clr1, clr2;
  logic bck1, lrck1, fv1, ov1, bck2, lrck2, fv2, ov2;
  logic [47:0]  fd1;
  logic [95:0]  fd2;
  logic         bck_s, lrck_s, fv_s, ov_s;
  logic [191:0] fd_s;
  logic [191:0] last_fd;
  logic [191:0] q[$];
  int checks = 0;
  int errors = 0;

  assign in1  = sel ? 1'b0 : din;
  assign in2  = sel ? din : 1'b0;
  assign rdy1 = sel ? 1'b1 : rdy;
  assign rdy2 = sel ? rdy : 1'b1;
  assign clr1 = sel ? 1'b0 : clr;
  assign clr2 = sel ? clr : 1'b0;
  assign bck_s  = sel ? bck2 : bck1;
  assign lrck_s = sel ? lrck2 : lrck1;
  assign fv_s   = sel ? fv2 : fv1;
  assign ov_s   = sel ? ov2 : ov1;
  assign fd_s   = sel ? {96'b0, fd2} : {144'b0, fd1};

  i2s_rx_tdm #(.SAMPLE_W(24), .SLOT_W(24), .CHANNELS(2), .SCK_PER_BCK(8), .MODE(0)) u_dut1 (
    .SCK(SCK), .begin_receive(rst1), .rx_en(en1), .in(in1), .BCK(bck1), .LRCK(lrck1),
    .frame_data(fd1), .frame_valid(fv1), .frame_ready(rdy1), .overrun(ov1),
    .clr_overrun(clr1));

  i2s_rx_tdm #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4), .SCK_PER_BCK(8), .MODE(1)) u_dut2 (
    .SCK(SCK), .begin_receive(rst2), .rx_en(en2), .in(in2), .BCK(bck2), .LRCK(lrck2),
    .frame_data(fd2), .frame_valid(fv2), .frame_ready(rdy2), .overrun(ov2),
    .clr_overrun(clr2));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] rnd_words(input int ch);
    logic [191:0] w;
    w = '0;
    for (int i = 0; i < ch; i++) w[i*24 +: 24] = 24'($urandom);
    return w;
  endfunction

  // Codec model: drives one frame starting right after the edge where the
  // receiver counters sit at zero; checks timing, commit and handshake.
  task automatic drive_frame(input int d, input logic [191:0] w,
                             input logic rdy_f, input logic rdy_c,
                             input logic clr_s, input logic clr_c,
                             input logic exp_drop, input logic pre_v,
                             input logic pre_o, input logic exp_o,
                             input int abort_k, input int rst_k);
    int sw, ch, md, n, p, s, b;
    logic [191:0] e;
    sw = (d == 1) ? 32 : 24;
    ch = (d == 1) ? 4 : 2;
    md = (d == 1) ? 1 : 0;
    n  = ch * sw * 8;
    sel = (d == 1);
    rdy = rdy_f;
    clr = clr_s;
    q.push_back(w);
    for (int k = 1; k <= n; k++) begin
      p = (k - 1) / 8;
      s = p / sw;
      b = p % sw;
      if ((k - 1) % 8 == 0) begin
        if (b >= md && b < md + 24) din = w[s*24 + 23 - (b - md)];
        else din = 1'($urandom_range(0, 1));
      end
      if (k == n - 3) begin
        rdy = rdy_c;
        clr = clr_c;
      end
      if (k == abort_k) begin
        if (d == 1) en2 = 1'b0; else en1 = 1'b0;
      end
      @(posedge SCK);
      #1;
      if (k == 1) clr = 1'b0;
      if (k == 3)  chk1("bck_low_e3", bck_s, 1'b0);
      if (k == 4)  chk1("bck_rise_e4", bck_s, 1'b1);
      if (k == 8)  chk1("bck_fall_e8", bck_s, 1'b0);
      if (k == 11) chk1("bck_low_e11", bck_s, 1'b0);
      if (k == 12) chk1("bck_rise_e12", bck_s, 1'b1);
      if (k == n / 2 - 1) chk1("lrck_before_half", lrck_s, 1'b1);
      if (k == n / 2)     chk1("lrck_fall_half", lrck_s, 1'b0);
      if (d == 1 && b == 5 && (k - 1) % 8 == 4) chk1("lrck_slot", lrck_s, (s < 2));
      if (k == n - 4) begin
        chk1("valid_pre_commit", fv_s, pre_v);
        chk1("overrun_pre_commit", ov_s, pre_o);
      end
      if (k == n - 3) begin
        e = q.pop_front();
        if (!exp_drop) begin
          last_fd = e;
          chkw("frame_data_load", fd_s, e);
          chk1("valid_at_commit", fv_s, 1'b1);
        end else begin
          chkw("frame_data_held", fd_s, last_fd);
        end
        chk1("overrun_at_commit", ov_s, exp_o);
        rdy = rdy_f;
        clr = 1'b0;
      end
      if (k == n - 2) chk1("valid_after_commit", fv_s, !rdy_f);
      if (k == abort_k) begin
        chk1("abort_bck", bck_s, 1'b0);
        chk1("abort_lrck", lrck_s, 1'b1);
        chk1("abort_valid", fv_s, pre_v);
        if (d == 1) en2 = 1'b1; else en1 = 1'b1;
        void'(q.pop_back());
        return;
      end
      if (k == rst_k) begin
        chk1("pre_rst_valid", fv_s, 1'b1);
        chk1("pre_rst_overrun", ov_s, 1'b1);
        chk1("pre_rst_bck", bck_s, 1'b1);
        #2;
        if (d == 1) rst2 = 1'b1; else rst1 = 1'b1;
        #1;
        chk1("async_rst_valid", fv_s, 1'b0);
        chk1("async_rst_bck", bck_s, 1'b0);
        chk1("async_rst_overrun", ov_s, 1'b0);
        chk1("async_rst_lrck", lrck_s, 1'b1);
        chkw("async_rst_data", fd_s, '0);
        @(posedge SCK);
        #1;
        if (d == 1) rst2 = 1'b0; else rst1 = 1'b0;
        void'(q.pop_back());
        return;
      end
    end
  endtask

  initial begin
    sel = 1'b0; rst1 = 1'b1; rst2 = 1'b1; en1 = 1'b1; en2 = 1'b0;
    din = 1'b0; rdy = 1'b1; clr = 1'b0; last_fd = '0;
    repeat (3) @(posedge SCK);
    #1;
    chk1("reset_bck", bck_s, 1'b0);
    chk1("reset_lrck", lrck_s, 1'b1);
    chk1("reset_valid", fv_s, 1'b0);
    chk1("reset_overrun", ov_s, 1'b0);
    chkw("reset_data", fd_s, '0);
    rst1 = 1'b0;
    rst2 = 1'b0;

    // A: basic LJ frame, consumer always ready
    drive_frame(0, {144'b0, 24'h800001, 24'hA5C3F1}, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // B, C, D: consumer stalled for three frames; clear collides with D's drop
    drive_frame(0, {144'b0, 24'h654321, 24'h123456}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_frame(0, {144'b0, 24'h000000, 24'hFFFFFF}, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    drive_frame(0, {144'b0, 24'h800000, 24'h7FFFFF}, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
    // E: overrun cleared, ready pulsed only on the commit edge
    drive_frame(0, {144'b0, 24'hF0F0F0, 24'h0F0F0F}, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    // F: consumer ready again
    drive_frame(0, {144'b0, 24'h13579B, 24'h246813}, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // G: rx_en dropped in slot 1 bit 10, then H decodes from a fresh start
    drive_frame(0, rnd_words(2), 1, 1, 0, 0, 0, 0, 0, 0, 8*34+6, 0);
    drive_frame(0, {144'b0, 24'h0BEEF0, 24'hDEADBE}, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // I, J: held frame plus overrun, then K is cut by an asynchronous reset
    drive_frame(0, {144'b0, 24'h222222, 24'h111111}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_frame(0, {144'b0, 24'h444444, 24'h333333}, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    drive_frame(0, rnd_words(2), 0, 0, 0, 0, 0, 1, 1, 1, 0, 8*30+6);

    en1 = 1'b0;
    en2 = 1'b1;
    drive_frame(1, {96'b0, 24'h123456, 24'h7FFFFF, 24'hFFFFFF, 24'h000001},
                1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_frame(1, rnd_words(4), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
